// File: rtl/argument_encoder.sv
// argument_encoder: packs variable-length fields (1..WIDTH_IN bits) LSB-first
// into a dense stream of WIDTH_OUT-bit words.
//
// Handshakes:
//   field in : a field is taken on a clock edge where push && !full && len != 0.
//   word out : q/q_valid are driven from registers only; a word leaves on an
//              edge where q_valid && q_ready. q_valid never depends on q_ready.
//   flush    : a flush request in RUN drains every buffered bit. The last
//              partial word is zero-padded. flush_done marks the cycle the
//              flush completes.
//
// Optional checking: define ARGUMENT_ENCODER_CHECK_EN to build a sticky
// error flag. It flags overflow pushes and bad lengths, and those fields are
// dropped. Without the macro, error is tied low.
module argument_encoder #(
   parameter int WIDTH_IN          = 64,
   parameter int WIDTH_OUT         = 64,
   parameter int LOG2_WIDTH_IN     = $clog2(WIDTH_IN),
   parameter int BUFFER_WIDTH      = WIDTH_IN + WIDTH_OUT,
   parameter int LOG2_BUFFER_WIDTH = $clog2(BUFFER_WIDTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [LOG2_WIDTH_IN:0] len,
   input  logic [WIDTH_IN-1:0]    d,
   output logic                   full,
   input  logic                   flush,
   output logic                   flush_done,
   output logic [WIDTH_OUT-1:0]   q,
   output logic                   q_valid,
   input  logic                   q_ready,
   output logic                   error
);

   localparam int CNT_W = LOG2_BUFFER_WIDTH;
   localparam logic [CNT_W-1:0] OUT_C   = CNT_W'(WIDTH_OUT);
   localparam logic [CNT_W-1:0] FULL_TH = CNT_W'(BUFFER_WIDTH - WIDTH_IN);

   // RUN packs fields. FLUSH drains whole words. PAD presents the last
   // partial word.
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_PAD   = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [BUFFER_WIDTH-1:0] buf_q, buf_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic                    pop;
   logic                    len_ok;
   logic                    accept;
   logic [BUFFER_WIDTH-1:0] field_w;

`ifdef ARGUMENT_ENCODER_CHECK_EN
   localparam logic [LOG2_WIDTH_IN:0] LEN_MAX = (LOG2_WIDTH_IN + 1)'(WIDTH_IN);
   logic error_q;

   // A field longer than the widest legal field is never packed.
   always_comb len_ok = (len <= LEN_MAX);

   // Sticky protocol-error flag. It reports each offending push once per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         error_q <= 1'b0;
      end else begin
         if (push && full) begin
            error_q <= 1'b1;
            $display("ERROR: overflow at %m");
         end
         if (push && (len > LEN_MAX)) begin
            error_q <= 1'b1;
            $display("ERROR: bad length at %m");
         end
      end
   end

   assign error = error_q;
`else
   assign len_ok = 1'b1;
   assign error  = 1'b0;
`endif

   // Outputs depend only on registers. full is conservative: it ignores any
   // pop in the same cycle.
   always_comb begin
      q          = buf_q[WIDTH_OUT-1:0];
      q_valid    = (state_q == ST_PAD) ? 1'b1 : (cnt_q >= OUT_C);
      full       = (cnt_q > FULL_TH) || (state_q != ST_RUN);
      flush_done = ((state_q == ST_FLUSH) && (cnt_q == '0)) ||
                   ((state_q == ST_PAD) && q_ready);
   end

   // Handshake qualifiers and the masked field, widened to the buffer width.
   always_comb begin
      pop     = q_valid && q_ready;
      accept  = push && !full && (len != '0) && len_ok;
      field_w = BUFFER_WIDTH'(d) & ~({BUFFER_WIDTH{1'b1}} << len);
   end

   // Next-state logic: the pop is applied first, so a same-cycle field lands
   // at the post-pop bit count. Then comes the flush sequencing.
   always_comb begin
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      if (pop) begin
         buf_d = buf_q >> WIDTH_OUT;
         cnt_d = cnt_q - OUT_C;
      end
      if (accept) begin
         buf_d = buf_d | (field_w << cnt_d);
         cnt_d = cnt_d + CNT_W'(len);
      end
      case (state_q)
         ST_RUN: begin
            if (flush) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (cnt_q == '0)        state_d = ST_RUN;
            else if (cnt_q < OUT_C) state_d = ST_PAD;
         end
         ST_PAD: begin
            if (q_ready) begin
               buf_d   = '0;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // State, buffer and bit-count registers. Reset discards everything,
   // including any flush in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         buf_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_argument_encoder.sv
// Self-checking bench for argument_encoder (default 64/64 build).
// The directed stimulus pushes the expected words into exp_q. A negedge
// monitor pops and compares every word that is handed off on q.
module tb_argument_encoder;

   localparam int WI = 64;
   localparam int WO = 64;
   localparam int LW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          push;
   logic [LW:0]   len;
   logic [WI-1:0] d;
   logic          full;
   logic          flush;
   logic          flush_done;
   logic [WO-1:0] q;
   logic          q_valid;
   logic          q_ready;
   logic          error;

   logic [WO-1:0] exp_q[$];
   int            n_checks = 0;
   int            n_pass   = 0;

   argument_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .len        (len),
      .d          (d),
      .full       (full),
      .flush      (flush),
      .flush_done (flush_done),
      .q          (q),
      .q_valid    (q_valid),
      .q_ready    (q_ready),
      .error      (error)
   );

   // Clock generation.
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_field(input logic [LW:0] l, input logic [WI-1:0] v);
      push = 1'b1;
      len  = l;
      d    = v;
      step();
      push = 1'b0;
      len  = '0;
      d    = '0;
   endtask

   // Request a flush, then wait (bounded) for flush_done.
   task automatic do_flush(input string name);
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (flush_done) break;
         step();
      end
      check(name, flush_done, 1);
      step();
   endtask

   // Scoreboard monitor: every handed-off word must match the queue head.
   always @(negedge clk) begin
      if (!rst && q_valid && q_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_word: got 0x%0h expected no word", q);
         end else begin
            check("word", q, exp_q.pop_front());
         end
      end
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst     = 1'b1;
      push    = 1'b0;
      len     = '0;
      d       = '0;
      flush   = 1'b0;
      q_ready = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      check("rst_q_valid", q_valid, 0);
      check("rst_full", full, 0);
      check("rst_flush_done", flush_done, 0);
      check("rst_error", error, 0);

      // Eight bytes form one word. A len=0 push in the middle is a no-op.
      exp_q.push_back(64'h0807060504030201);
      for (int i = 1; i <= 8; i++) begin
         push_field(7'd8, WI'(i));
         if (i == 4) push_field(7'd0, 64'hFF);
      end
      check("t8_valid", q_valid, 1);
      check("t8_q", q, 64'h0807060504030201);
      step();
      check("t8_valid_after_pop", q_valid, 0);

      // Twelve bytes in a row. The ninth is accepted in the same cycle as
      // the pop, and a flush pads out the remainder.
      exp_q.push_back(64'h1716151413121110);
      exp_q.push_back(64'h000000001B1A1918);
      for (int i = 0; i < 12; i++) push_field(7'd8, WI'(8'h10 + i));
      do_flush("t12_flush_done");
      check("t12_full_after", full, 0);

      // Two 40-bit fields straddle a word boundary.
      exp_q.push_back(64'h111111ABCDEF0123);
      exp_q.push_back(64'h0000000000001111);
      push_field(7'd40, 64'hFFFFFFABCDEF0123);
      push_field(7'd40, 64'h0000001111111111);
      check("t40_valid", q_valid, 1);
      do_flush("t40_flush_done");

      // Backpressure: two full words, then a push while full is dropped.
      q_ready = 1'b0;
      exp_q.push_back(64'hA5A5A5A5_12345678);
      exp_q.push_back(64'h5A5A5A5A_87654321);
      push_field(7'd64, 64'hA5A5A5A5_12345678);
      check("bp_full_1", full, 0);
      check("bp_valid_1", q_valid, 1);
      push_field(7'd64, 64'h5A5A5A5A_87654321);
      check("bp_full_2", full, 1);
      push_field(7'd8, 64'hCC);
      check("bp_full_drop", full, 1);
      check("bp_error", error, 0);
      q_ready = 1'b1;
      step();
      check("bp_full_after_pop", full, 0);
      check("bp_valid_after_pop", q_valid, 1);
      step();
      check("bp_valid_end", q_valid, 0);
      check("bp_full_end", full, 0);

      // A 12-bit field with a flush walks through FLUSH and PAD.
      q_ready = 1'b0;
      exp_q.push_back(64'h0000000000000ABC);
      push_field(7'd12, 64'hFFFF_FFFF_FFFF_FABC);
      check("pad_valid_run", q_valid, 0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("pad_full_flush", full, 1);
      check("pad_valid_flush", q_valid, 0);
      check("pad_done_flush", flush_done, 0);
      step();
      check("pad_valid", q_valid, 1);
      check("pad_q", q, 64'h0000000000000ABC);
      check("pad_full", full, 1);
      check("pad_done_wait", flush_done, 0);
      q_ready = 1'b1;
      #1;
      check("pad_done_pulse", flush_done, 1);
      step();
      check("pad_done_clear", flush_done, 0);
      check("pad_valid_clear", q_valid, 0);
      check("pad_full_clear", full, 0);

      // A flush of an empty buffer completes one cycle later with no word.
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("empty_flush_done", flush_done, 1);
      check("empty_flush_valid", q_valid, 0);
      step();
      check("empty_flush_done_clear", flush_done, 0);

      // A mid-operation reset discards buffered bits.
      push_field(7'd20, 64'hFFFFF);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_valid", q_valid, 0);
      check("mid_rst_full", full, 0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("mid_rst_flush_done", flush_done, 1);
      step();
      exp_q.push_back(64'h000000000000005A);
      push_field(7'd8, 64'h5A);
      push_field(7'd56, 64'h0);
      check("mid_rst_word_valid", q_valid, 1);
      step();

      repeat (3) step();
      check("exp_q_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
